// File: rtl/r5_pkg.sv
// Shared constants and types for the radix-5 FFT front end.
package r5_pkg;

  localparam int NPTS    = 5;
  localparam int FP_W    = 32;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam logic [7:0] EXP_INF = 8'hFF;

  localparam logic [2:0] LAST_IDX = 3'(NPTS - 1);

  typedef struct packed {
    logic [FP_W-1:0] re;
    logic [FP_W-1:0] img;
  } cplx_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } coll_state_e;

endpackage

// File: rtl/fp_pow2_scale.sv
// Combinational power-of-two down-scale of one IEEE-754 single by exponent
// subtract. Results that would become denormal are flushed to signed zero.
module fp_pow2_scale
  import r5_pkg::*;
#(
  parameter int unsigned SHIFT = 4
) (
  input  logic [FP_W-1:0] val_i,
  output logic [FP_W-1:0] val_o,
  output logic            uflow_o
);

  localparam logic [7:0] SHIFT_E = 8'(SHIFT);

  logic [7:0] exp_w;
  assign exp_w = val_i[EXP_MSB:EXP_LSB];

  // Inf/NaN pass through; zero/denormal become signed zero without flagging;
  // exponents that cannot absorb the shift flush to signed zero and flag it.
  always_comb begin
    val_o   = val_i;
    uflow_o = 1'b0;
    if (exp_w != EXP_INF) begin
      if (exp_w == 8'd0) begin
        val_o = {val_i[FP_W-1], {(FP_W-1){1'b0}}};
      end else if (exp_w <= SHIFT_E) begin
        val_o   = {val_i[FP_W-1], {(FP_W-1){1'b0}}};
        uflow_o = 1'b1;
      end else begin
        val_o[EXP_MSB:EXP_LSB] = exp_w - SHIFT_E;
      end
    end
  end

endmodule

// File: rtl/r5_input_gather.sv
// Radix-5 FFT input gather: scales each incoming complex sample, collects
// five of them, then hands the frame to a decoupling output register.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_FILL | collecting lanes idx 0..4, input accepted
// ST_FULL | all five lanes written, output register busy, input stalled
module r5_input_gather
  import r5_pkg::*;
#(
  parameter int unsigned SHIFT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FP_W-1:0]      in_re,
  input  logic [FP_W-1:0]      in_img,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NPTS*FP_W-1:0] out_re,
  output logic [NPTS*FP_W-1:0] out_img,
  output logic                 out_uflow
);

  coll_state_e state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  cplx_t       coll_q [NPTS];
  cplx_t       coll_d [NPTS];
  cplx_t       obank_q [NPTS];
  logic        coll_uf_q, coll_uf_d;
  logic        out_valid_q, out_valid_d;
  logic        out_uflow_q, out_uflow_d;

  cplx_t       scaled;
  logic        uf_re, uf_img, s_uf;
  logic        accept, last, out_free, uf_acc, xfer;

  fp_pow2_scale #(.SHIFT(SHIFT)) u_scale_re (
    .val_i   (in_re),
    .val_o   (scaled.re),
    .uflow_o (uf_re)
  );

  fp_pow2_scale #(.SHIFT(SHIFT)) u_scale_img (
    .val_i   (in_img),
    .val_o   (scaled.img),
    .uflow_o (uf_img)
  );

  assign s_uf     = uf_re | uf_img;
  assign in_ready = (state_q == ST_FILL);
  assign accept   = in_valid && in_ready;
  assign last     = accept && (idx_q == LAST_IDX);
  assign out_free = !out_valid_q || out_ready;
  // The underflow flag restarts with the first lane of every frame.
  assign uf_acc   = ((idx_q == 3'd0) ? 1'b0 : coll_uf_q) | s_uf;

  // Next-state: lane write, index wrap, FILL/FULL, transfer and drain; clr wins.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    coll_d      = coll_q;
    coll_uf_d   = coll_uf_q;
    out_valid_d = out_valid_q;
    out_uflow_d = out_uflow_q;
    xfer        = 1'b0;

    if (accept) begin
      for (int k = 0; k < NPTS; k++) begin
        if (idx_q == 3'(k)) coll_d[k] = scaled;
      end
      coll_uf_d = uf_acc;
      idx_d     = last ? 3'd0 : idx_q + 3'd1;
    end

    xfer = (last || (state_q == ST_FULL)) && out_free;

    if (last && !out_free) begin
      state_d = ST_FULL;
    end else if (xfer) begin
      state_d = ST_FILL;
    end

    if (xfer) begin
      out_valid_d = 1'b1;
      out_uflow_d = coll_uf_d;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_uflow_d = 1'b0;
    end

    if (clr) begin
      state_d     = ST_FILL;
      idx_d       = 3'd0;
      out_valid_d = 1'b0;
      out_uflow_d = 1'b0;
      xfer        = 1'b0;
    end
  end

  // Control and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      idx_q       <= 3'd0;
      coll_uf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_uflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      coll_uf_q   <= coll_uf_d;
      out_valid_q <= out_valid_d;
      out_uflow_q <= out_uflow_d;
    end
  end

  // Collect bank and output frame register; clr leaves data stale on purpose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NPTS; k++) begin
        coll_q[k]  <= '0;
        obank_q[k] <= '0;
      end
    end else begin
      coll_q <= coll_d;
      if (xfer) obank_q <= coll_d;
    end
  end

  // Flatten the output frame into lanes, lane 0 in the low bits.
  always_comb begin
    out_re  = '0;
    out_img = '0;
    for (int k = 0; k < NPTS; k++) begin
      out_re[k*FP_W +: FP_W]  = obank_q[k].re;
      out_img[k*FP_W +: FP_W] = obank_q[k].img;
    end
  end

  assign out_valid = out_valid_q;
  assign out_uflow = out_uflow_q;

endmodule

// File: tb/tb_r5_input_gather.sv
// Directed and randomized bench for r5_input_gather with a queue-based
// reference model of scaling and frame gathering.
module tb_r5_input_gather;

  localparam int SHIFT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [31:0]  in_re = '0;
  logic [31:0]  in_img = '0;
  logic         in_ready, out_valid, out_uflow;
  logic [159:0] out_re, out_img;

  int total = 0;
  int bad = 0;
  int frames_out = 0;

  logic [31:0]  p_re[$];
  logic [31:0]  p_im[$];
  bit           p_uf = 1'b0;
  logic [159:0] e_re[$];
  logic [159:0] e_im[$];
  bit           e_uf[$];

  bit           hold_pending = 1'b0;
  logic [159:0] h_re, h_im;
  logic         h_uf;

  r5_input_gather #(.SHIFT(SHIFT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_img    (in_img),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_img   (out_img),
    .out_uflow (out_uflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Scale by 2^-SHIFT: resulting exponent below 1 means flush to signed zero.
  function automatic logic [32:0] ref_scale(input logic [31:0] x);
    int e, ne;
    e  = int'(x[30:23]);
    ne = e - SHIFT;
    if (e == 255) return {1'b0, x};
    if (e == 0) return {1'b0, x[31], 31'b0};
    if (ne < 1) return {1'b1, x[31], 31'b0};
    return {1'b0, x[31], 8'(ne), x[22:0]};
  endfunction

  function automatic logic [159:0] frm(input logic [31:0] base);
    logic [159:0] f;
    for (int k = 0; k < 5; k++) f[k*32 +: 32] = base + 32'(k);
    return f;
  endfunction

  function automatic logic [31:0] rnd_fp();
    int unsigned sel, s, m;
    logic [7:0] e;
    sel = $urandom_range(0, 5);
    s   = $urandom_range(0, 1);
    m   = $urandom;
    case (sel)
      0:       e = 8'd0;
      1:       e = 8'($urandom_range(1, SHIFT));
      2:       e = 8'd255;
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {s[0], e, m[22:0]};
  endfunction

  task automatic chk_w(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int expv);
    total++;
    assert (obs == expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_accept(input logic [31:0] re, input logic [31:0] im);
    logic [32:0]  sr, si;
    logic [159:0] fr, fi;
    sr = ref_scale(re);
    si = ref_scale(im);
    p_re.push_back(sr[31:0]);
    p_im.push_back(si[31:0]);
    p_uf = p_uf | sr[32] | si[32];
    if (p_re.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        fr[k*32 +: 32] = p_re[k];
        fi[k*32 +: 32] = p_im[k];
      end
      e_re.push_back(fr);
      e_im.push_back(fi);
      e_uf.push_back(p_uf);
      p_re.delete();
      p_im.delete();
      p_uf = 1'b0;
    end
  endtask

  task automatic flush();
    p_re.delete();
    p_im.delete();
    p_uf = 1'b0;
    e_re.delete();
    e_im.delete();
    e_uf.delete();
    hold_pending = 1'b0;
  endtask

  // One clock: check held output, score handshakes, advance to next negedge.
  task automatic step();
    bit acc, ody;
    if (hold_pending) begin
      chk_b("hold_valid", out_valid, 1'b1);
      chk_w("hold_re", out_re, h_re);
      chk_w("hold_img", out_img, h_im);
      chk_b("hold_uflow", out_uflow, h_uf);
      hold_pending = 1'b0;
    end
    acc = in_valid && in_ready;
    ody = out_valid && out_ready;
    if (clr) begin
      flush();
    end else begin
      if (ody) begin
        frames_out++;
        chk_b("frame_expected", e_re.size() > 0, 1'b1);
        if (e_re.size() > 0) begin
          chk_w("frame_re", out_re, e_re.pop_front());
          chk_w("frame_img", out_img, e_im.pop_front());
          chk_b("frame_uflow", out_uflow, e_uf.pop_front());
        end
      end
      if (acc) model_accept(in_re, in_img);
      if (out_valid && !out_ready) begin
        hold_pending = 1'b1;
        h_re = out_re;
        h_im = out_img;
        h_uf = out_uflow;
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] re, input logic [31:0] im);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_re    = re;
    in_img   = im;
    for (int i = 0; i < 40 && !done; i++) begin
      done = in_ready;
      step();
    end
    chk_b("send_accepted", done, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flush();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int f0;
    logic [31:0] v;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_b("rst_in_ready", in_ready, 1'b1);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_b("rst_out_uflow", out_uflow, 1'b0);
    chk_w("rst_out_re", out_re, 160'd0);
    chk_w("rst_out_img", out_img, 160'd0);

    // 1. Basic scaling and latency
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      chk_b("t1_no_early_valid", out_valid, 1'b0);
      send(32'h3F800000, 32'h3F800000);
    end
    chk_b("t1_latency_valid", out_valid, 1'b1);
    chk_w("t1_re", out_re, {5{32'h3D800000}});
    chk_w("t1_img", out_img, {5{32'h3D800000}});
    chk_b("t1_uflow", out_uflow, 1'b0);
    idle(2);

    // 2. Underflow flush in lane 2
    for (int n = 0; n < 5; n++) begin
      if (n == 2) send(32'h01800000, 32'h81800000);
      else        send(32'h3F800000, 32'h3F800000);
    end
    chk_w("t2_re", out_re, 160'h3D800000_3D800000_00000000_3D800000_3D800000);
    chk_w("t2_img", out_img, 160'h3D800000_3D800000_80000000_3D800000_3D800000);
    chk_b("t2_uflow", out_uflow, 1'b1);
    idle(2);

    // 3. Special values
    send(32'h7F800000, 32'h7F800000);
    send(32'h7FC00000, 32'h7FC00000);
    send(32'h00000001, 32'h00000001);
    send(32'h80000000, 32'h80000000);
    send(32'h3F800000, 32'h3F800000);
    chk_w("t3_re", out_re, 160'h3D800000_80000000_00000000_7FC00000_7F800000);
    chk_w("t3_img", out_img, 160'h3D800000_80000000_00000000_7FC00000_7F800000);
    chk_b("t3_uflow", out_uflow, 1'b0);
    idle(2);

    // 4. Backpressure
    out_ready = 1'b0;
    for (int n = 1; n <= 10; n++) send(32'h40000000 + 32'(n), 32'h40000000 + 32'(n));
    chk_b("t4_in_ready_low", in_ready, 1'b0);
    in_valid = 1'b1;
    in_re    = 32'h4000000B;
    in_img   = 32'h4000000B;
    step();
    step();
    chk_b("t4_still_stalled", in_ready, 1'b0);
    chk_w("t4_frame1_held", out_re, frm(32'h3E000001));
    out_ready = 1'b1;
    step();
    chk_b("t4_frame2_valid", out_valid, 1'b1);
    chk_b("t4_in_ready_back", in_ready, 1'b1);
    chk_w("t4_frame2_re", out_re, frm(32'h3E000006));
    for (int n = 11; n <= 15; n++) send(32'h40000000 + 32'(n), 32'h40000000 + 32'(n));
    chk_w("t4_frame3_re", out_re, frm(32'h3E00000B));
    idle(2);

    // 5a. Reset mid-frame
    for (int n = 0; n < 3; n++) send(32'h3F800000, 32'h3F800000);
    do_reset();
    chk_b("t5_rst_valid", out_valid, 1'b0);
    chk_b("t5_rst_ready", in_ready, 1'b1);
    f0 = frames_out;
    for (int n = 0; n < 5; n++) send(32'h40000000 + 32'(n), 32'h40000000 + 32'(n));
    chk_w("t5_rst_re", out_re, frm(32'h3E000000));
    chk_w("t5_rst_img", out_img, frm(32'h3E000000));
    idle(4);
    chk_i("t5_rst_frames", frames_out - f0, 1);

    // 5b. Clear mid-frame
    for (int n = 0; n < 3; n++) send(32'h3F800000, 32'h3F800000);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk_b("t5_clr_valid", out_valid, 1'b0);
    f0 = frames_out;
    for (int n = 0; n < 5; n++) send(32'h40000000 + 32'(n), 32'h40000000 + 32'(n));
    chk_w("t5_clr_re", out_re, frm(32'h3E000000));
    chk_w("t5_clr_img", out_img, frm(32'h3E000000));
    idle(4);
    chk_i("t5_clr_frames", frames_out - f0, 1);

    // 5c. Clear while a frame is held and another waits in the collect bank
    out_ready = 1'b0;
    for (int n = 0; n < 10; n++) send(32'h3F800000, 32'h3F800000);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk_b("t5_clr_full_valid", out_valid, 1'b0);
    chk_b("t5_clr_full_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    idle(3);

    // 6. Streaming
    f0 = frames_out;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      chk_b("t6_in_ready", in_ready, 1'b1);
      chk_b("t6_valid_pattern", out_valid, (i > 0) && (i % 5 == 0));
      v = rnd_fp();
      in_re = v;
      v = rnd_fp();
      in_img = v;
      step();
    end
    idle(3);
    chk_i("t6_frames", frames_out - f0, 10);

    // 7. Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 60) == 0);
      v = rnd_fp();
      in_re = v;
      v = rnd_fp();
      in_img = v;
      step();
    end
    clr       = 1'b0;
    out_ready = 1'b1;
    idle(6);
    chk_i("t7_drained", e_re.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
